// File: rtl/instr_enc.sv
// instr_enc: encodes MIPS operation descriptors into 32-bit instruction words
// and queues them in a DEPTH-word output FIFO with valid/ready handshakes.
// Optional build macro INSTR_ENC_DELAY_SLOT_EN: jr/beq/j/jal also enqueue a
// trailing nop (0x00000000) into the next FIFO slot on the same edge.
module instr_enc #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [25:0]              in_field,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADDU  = 4'd0,
    OP_SUBU  = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_SLL   = 4'd5,
    OP_JR    = 4'd6,
    OP_ORI   = 4'd7,
    OP_LUI   = 4'd8,
    OP_ADDIU = 4'd9,
    OP_LW    = 4'd10,
    OP_SW    = 4'd11,
    OP_BEQ   = 4'd12,
    OP_J     = 4'd13,
    OP_JAL   = 4'd14,
    OP_RSV   = 4'd15
  } op_e;

  op_e           op;
  logic [31:0]   word;
  logic          is_rsv;
  logic          accept;
  logic          pop;
  logic [PW:0]   wr_adv;
  logic [PW:0]   count_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem [DEPTH];

  assign op = op_e'(in_op);

  // Encode the offered descriptor into its MIPS word
  always_comb begin
    word   = '0;
    is_rsv = 1'b0;
    case (op)
      OP_ADDU:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      OP_SUBU:  word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      OP_AND:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
      OP_OR:    word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
      OP_SLT:   word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
      OP_SLL:   word = {6'h00, 5'd0, in_rt, in_rd, in_field[4:0], 6'h00};
      OP_JR:    word = {6'h00, in_rs, 5'd0, 5'd0, 5'd0, 6'h08};
      OP_ORI:   word = {6'h0D, in_rs, in_rt, in_field[15:0]};
      OP_LUI:   word = {6'h0F, 5'd0, in_rt, in_field[15:0]};
      OP_ADDIU: word = {6'h09, in_rs, in_rt, in_field[15:0]};
      OP_LW:    word = {6'h23, in_rs, in_rt, in_field[15:0]};
      OP_SW:    word = {6'h2B, in_rs, in_rt, in_field[15:0]};
      OP_BEQ:   word = {6'h04, in_rs, in_rt, in_field[15:0]};
      OP_J:     word = {6'h02, in_field};
      OP_JAL:   word = {6'h03, in_field};
      OP_RSV:   is_rsv = 1'b1;
      default:  is_rsv = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_DELAY_SLOT_EN
  logic          slot2;
  logic [PW-1:0] wr_nxt;
  localparam logic [PW:0] READY_MAX = (PW+1)'(DEPTH - 2);

  assign slot2    = (op == OP_JR) || (op == OP_BEQ) || (op == OP_J) || (op == OP_JAL);
  assign wr_nxt   = wr_ptr + PW'(1);
  // Readiness is judged on registered occupancy so a pop cannot raise it this cycle
  assign in_ready = (count <= READY_MAX);
`else
  localparam logic [PW:0] READY_LIM = (PW+1)'(DEPTH);

  // Readiness is judged on registered occupancy so a pop cannot raise it this cycle
  assign in_ready = (count < READY_LIM);
`endif

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : '0;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Number of slots written this cycle and the resulting occupancy
  always_comb begin
    wr_adv = '0;
    if (accept) begin
`ifdef INSTR_ENC_DELAY_SLOT_EN
      wr_adv = slot2 ? (PW+1)'(2) : (PW+1)'(1);
`else
      wr_adv = (PW+1)'(1);
`endif
    end
    count_nxt = count + wr_adv - {{PW{1'b0}}, pop};
  end

  // FIFO storage write (contents need no reset; out_instr is gated by out_valid)
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= word;
`ifdef INSTR_ENC_DELAY_SLOT_EN
      if (slot2) mem[wr_nxt] <= '0;
`endif
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_adv[PW-1:0];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
    end
  end

  // Sticky flag for an accepted reserved op
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else if (accept && is_rsv) err <= 1'b1;
  end

endmodule

// File: tb/tb_instr_enc.sv
// tb_instr_enc: scoreboard bench for instr_enc. The driver pushes expected
// words when a descriptor is accepted; a negedge monitor pops and compares.
module tb_instr_enc;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
  localparam int LIM   = DEPTH - 2;
`else
  localparam int LIM   = DEPTH - 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [25:0]   in_field;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [CW-1:0] count;
  logic          err;

  instr_enc #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_field(in_field), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] q[$];
  logic        exp_err = 1'b0;
  logic        mon_en  = 1'b0;
  int          rdy_mode = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field positions with plain arithmetic
  function automatic logic [31:0] model(input int op, input int rs, input int rt,
                                        input int rd, input int fld);
    int unsigned opc, f, r_s, r_t, r_d, sh;
    r_s = rs % 32; r_t = rt % 32; r_d = rd % 32; sh = 0;
    if (op <= 6) begin
      case (op)
        0: f = 'h21; 1: f = 'h23; 2: f = 'h24; 3: f = 'h25;
        4: f = 'h2A; 5: f = 'h00; default: f = 'h08;
      endcase
      if (op == 5) begin r_s = 0; sh = fld % 32; end
      if (op == 6) begin r_t = 0; r_d = 0; end
      return r_s * (1 << 21) + r_t * (1 << 16) + r_d * (1 << 11) + sh * 64 + f;
    end else if (op <= 12) begin
      case (op)
        7: opc = 'h0D; 8: opc = 'h0F; 9: opc = 'h09;
        10: opc = 'h23; 11: opc = 'h2B; default: opc = 'h04;
      endcase
      if (op == 8) r_s = 0;
      return opc * (1 << 26) + r_s * (1 << 21) + r_t * (1 << 16) + (fld % 65536);
    end else if (op <= 14) begin
      return (op - 11) * (1 << 26) + (fld % (1 << 26));
    end
    return 32'h0;
  endfunction

  function automatic bit has_slot(input int op);
    return (op == 6) || (op == 12) || (op == 13) || (op == 14);
  endfunction

  // Consumer readiness: 0 always ready, 1 never ready, 2 random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: compares status and the FIFO head against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() <= LIM));
      chk("err", 32'(err), 32'(exp_err));
      if (out_valid && q.size() != 0) begin
        chk("out_instr", out_instr, q[0]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  // Offer one descriptor; called at posedge+1, returns at posedge+1
  task automatic offer(input int op, input int rs, input int rt, input int rd,
                       input int fld, input logic [31:0] exp);
    bit acc = 1'b0;
    int opv = op;
    in_op = opv[3:0]; in_rs = rs[4:0]; in_rt = rt[4:0]; in_rd = rd[4:0];
    in_field = fld[25:0];
    in_valid = 1'b1;
    for (int c = 0; c < 1000 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      if (acc) begin
        q.push_back(exp);
`ifdef INSTR_ENC_DELAY_SLOT_EN
        if (has_slot(op)) q.push_back(32'h0);
`endif
        if (op == 15) exp_err = 1'b1;
      end
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 2000 && q.size() != 0; c++) @(posedge clk);
    chk("drain", 32'(q.size() == 0), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int fill_n;
    reset_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0;
    in_rd = '0; in_field = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; mon_en = 1'b1;

    // addu with an always-ready consumer
    offer(0, 1, 2, 3, 0, 32'h00221821);
    drain();
    @(negedge clk);
    chk("count_back_to_zero", 32'(count), 32'd0);
    @(posedge clk); #1;

    // ori then lui, in order
    offer(7, 0, 1, 0, 'h1234, 32'h34011234);
    offer(8, 9, 8, 0, 'hABCD, 32'h3C08ABCD);
    drain();

    // Fill with consumer stalled, then release
    rdy_mode = 1;
    @(posedge clk); #1;
`ifdef INSTR_ENC_DELAY_SLOT_EN
    fill_n = DEPTH - 1;
`else
    fill_n = DEPTH;
`endif
    for (int i = 0; i < fill_n; i++) offer(1, i + 4, i + 5, i + 6, 0, model(1, i + 4, i + 5, i + 6, 0));
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'(fill_n));
    @(posedge clk); #1;
    rdy_mode = 0;
    offer(3, 7, 8, 9, 0, 32'h00E84825);
    drain();

    // beq and j (nop follows each when delay slots are built in)
    offer(12, 1, 2, 0, 'hFFFF, 32'h1022FFFF);
    offer(13, 0, 0, 0, 'h0000100, 32'h08000100);
    drain();

    // Reserved op sets sticky err
    offer(15, 3, 4, 5, 'h123, 32'h0);
    offer(9, 2, 3, 0, 'h8000, model(9, 2, 3, 0, 'h8000));
    offer(5, 31, 6, 7, 'h1F, model(5, 31, 6, 7, 'h1F));
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    @(posedge clk); #1;

    // Reset mid-stream discards queued words
    rdy_mode = 1;
    offer(10, 1, 2, 0, 'h10, model(10, 1, 2, 0, 'h10));
    offer(14, 0, 0, 0, 'h3FFFFFF, model(14, 0, 0, 0, 'h3FFFFFF));
    #2; mon_en = 1'b0; reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_instr", out_instr, 32'h0);
    q.delete(); exp_err = 1'b0; rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1; mon_en = 1'b1;

    // Randomized traffic with random consumer stalls
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      int op, rs, rt, rd, fld;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op = $urandom_range(0, 15);
      if (op == 15 && $urandom_range(0, 3) != 0) op = $urandom_range(0, 14);
      rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
      fld = int'($urandom() & 32'h03FF_FFFF);
      offer(op, rs, rt, rd, fld, model(op, rs, rt, rd, fld));
    end
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_enc.md
INSTR_ENC -- requirements
Module: instr_enc

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the output FIFO depth in words; legal values are powers of two, 2 to 16.
REQ-002 Port clk, input, 1: SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1: SHALL be the asynchronous, active-low reset.
REQ-004 Port in_valid, input, 1: SHALL mark that an operation descriptor is offered.
REQ-005 Port in_ready, output, 1: SHALL mark that the block accepts a descriptor this cycle.
REQ-006 Port in_op, input, 4: SHALL select the operation: 0 addu, 1 subu, 2 and, 3 or, 4 slt, 5 sll, 6 jr, 7 ori, 8 lui, 9 addiu, 10 lw, 11 sw, 12 beq, 13 j, 14 jal, 15 reserved.
REQ-007 Ports in_rs, in_rt, in_rd, input, 5 each: SHALL carry the register fields.
REQ-008 Port in_field, input, 26: SHALL carry the immediate in [15:0], the jump target in [25:0], or the shift amount in [4:0].
REQ-009 Port out_valid, output, 1: SHALL mark that out_instr holds a valid word (FIFO not empty).
REQ-010 Port out_ready, input, 1: SHALL mark that the consumer takes the word this cycle.
REQ-011 Port out_instr, output, 32: SHALL present the encoded MIPS word at the FIFO head.
REQ-012 Port count, output, log2(DEPTH)+1: SHALL report the FIFO occupancy.
REQ-013 Port err, output, 1: SHALL be the sticky flag for a reserved op.

Function
REQ-014 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 The encoded word SHALL be written into the FIFO at the accept edge and SHALL be visible on out_instr on the next cycle when the FIFO was empty (latency 1).
REQ-016 R-type words SHALL be {6'h00, rs, rt, rd, shamt, funct} with funct addu 0x21, subu 0x23, and 0x24, or 0x25, slt 0x2A, jr 0x08.
REQ-017 shamt SHALL be 0 for every R-type op except sll, which SHALL use in_field[4:0] with rs forced to 0 and funct 0x00.
REQ-018 jr SHALL force rt and rd to 0.
REQ-019 I-type words SHALL be {opcode, rs, rt, in_field[15:0]} with opcode ori 0x0D, lui 0x0F, addiu 0x09, lw 0x23, sw 0x2B, beq 0x04.
REQ-020 lui SHALL force rs to 0.
REQ-021 J-type words SHALL be {opcode, in_field[25:0]} with opcode j 0x02, jal 0x03.
REQ-022 An accepted op 15 SHALL enqueue 0x00000000 and set err; err SHALL clear only on reset.
REQ-023 in_ready SHALL be 1 when count < DEPTH, evaluated so that a simultaneous pop does not raise in_ready in the same cycle.
REQ-024 Simultaneous accept and pop SHALL leave count unchanged and preserve word order.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-026 A pop when empty or a push when full SHALL be impossible by construction, since out_valid is 0 when empty and in_ready is 0 when full.

Reset
REQ-027 On reset_n low the block SHALL immediately clear the pointers, count, and err; out_valid = 0, in_ready = 1, and out_instr = 0x00000000.
REQ-028 Reset mid-operation SHALL discard all queued words; no partial word SHALL appear after release.

Configuration
REQ-029 Macro INSTR_ENC_DELAY_SLOT_EN, when defined, SHALL make every accepted jr, beq, j, or jal enqueue the encoded word followed by 0x00000000 (nop) in the next FIFO slot at the same edge.
REQ-030 With the macro defined, in_ready SHALL require count <= DEPTH-2 and count SHALL advance by 2 (or by 1 with a simultaneous pop) for those ops.
REQ-031 With the macro undefined, every op SHALL enqueue exactly one word and no nop SHALL be inserted.

Verification
REQ-032 addu rs=1 rt=2 rd=3, out_ready=1 -> out_instr 0x00221821 one cycle later, and count returns to 0.
REQ-033 ori rs=0 rt=1 field=0x1234, then lui rt=8 field=0xABCD -> 0x34011234, then 0x3C08ABCD, in order.
REQ-034 out_ready=0 with DEPTH+1 offers -> in_ready drops after DEPTH accepts and count=DEPTH; raise out_ready -> words drain in order and in_ready returns.
REQ-035 beq rs=1 rt=2 field=0xFFFF, then j field=0x0000100 -> 0x1022FFFF, 0x08000100; with INSTR_ENC_DELAY_SLOT_EN, a 0x00000000 follows each of them.
REQ-036 op=15 -> 0x00000000 enqueued and err=1; err stays 1 across later valid ops; assert reset_n=0 mid-stream -> out_valid=0, count=0, err=0 immediately.
